// File: rtl/fe_pc_sequencer.sv
// fe_pc_sequencer: fetch-side PC sequencer and consumer of the AGEX->FE redirect interface.
// Owns the fetch PC, the instruction-count tag and issue-valid into the FE/DE latch. After a
// control-flow instruction issues, fetch stalls in BR_WAIT until AGEX either redirects
// (br_taken_i) or confirms the fall-through path (br_resolved_i).
// Optional build macro FE_PERF_CNT_EN adds saturating stall / branch-wait / redirect counters.
module fe_pc_sequencer #(
  parameter int                DBITS      = 32,
  parameter int                INSTBITS   = 32,
  parameter logic [DBITS-1:0]  RESET_PC   = '0,
  parameter int                WAIT_LIMIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INSTBITS-1:0] imem_inst_i,
  input  logic                de_stall_i,
  input  logic                br_taken_i,
  input  logic [DBITS-1:0]    br_target_i,
  input  logic                br_resolved_i,
  output logic [DBITS-1:0]    pc_o,
  output logic [DBITS-1:0]    pcplus_o,
  output logic [INSTBITS-1:0] inst_o,
  output logic [DBITS-1:0]    inst_count_o,
  output logic                fe_valid_o,
  output logic                br_wait_o,
  output logic                misalign_o,
  output logic                wdog_o
`ifdef FE_PERF_CNT_EN
  ,
  output logic [31:0]         perf_stall_o,
  output logic [31:0]         perf_brwait_o,
  output logic [31:0]         perf_redir_o
`endif
);

  localparam int             WCW  = $clog2(WAIT_LIMIT + 1);
  localparam logic [WCW-1:0] WLIM = WCW'(WAIT_LIMIT);

  typedef enum logic {RUN, BR_WAIT} state_t;

  state_t           state, state_next;
  logic [DBITS-1:0] pc, pc_next;
  logic [DBITS-1:0] count, count_next;
  logic [WCW-1:0]   wait_cnt, wait_cnt_next;
  logic             misalign, misalign_next;
  logic             wdog, wdog_next;
  logic             is_cf;
  logic             issue;

  // Predecode: branches, JAL and JALR all need AGEX to resolve before fetch may continue.
  always_comb begin
    is_cf = (imem_inst_i[6:0] == 7'b1100011) ||
            (imem_inst_i[6:0] == 7'b1101111) ||
            (imem_inst_i[6:0] == 7'b1100111);
  end

  assign issue = (state == RUN) && !de_stall_i;

  // Next-state logic: sequential fetch in RUN, redirect/resume/watchdog handling in BR_WAIT.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    count_next    = count;
    wait_cnt_next = wait_cnt;
    misalign_next = misalign;
    wdog_next     = wdog;
    case (state)
      RUN: begin
        if (issue) begin
          pc_next    = pc + DBITS'(4);
          count_next = count + DBITS'(1);
          if (is_cf) begin
            state_next    = BR_WAIT;
            wait_cnt_next = '0;
          end
        end
      end
      BR_WAIT: begin
        if (wait_cnt != WLIM) begin
          wait_cnt_next = wait_cnt + WCW'(1);
        end
        if (br_taken_i) begin
          pc_next       = {br_target_i[DBITS-1:2], 2'b00};
          misalign_next = misalign | (|br_target_i[1:0]);
          state_next    = RUN;
        end else if (br_resolved_i) begin
          state_next = RUN;
        end else if (wait_cnt_next == WLIM) begin
          wdog_next = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // State register; reset overrides every other input, including a redirect mid-BR_WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      pc       <= RESET_PC;
      count    <= '0;
      wait_cnt <= '0;
      misalign <= 1'b0;
      wdog     <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      count    <= count_next;
      wait_cnt <= wait_cnt_next;
      misalign <= misalign_next;
      wdog     <= wdog_next;
    end
  end

  assign pc_o         = pc;
  assign pcplus_o     = pc + DBITS'(4);
  assign fe_valid_o   = issue;
  assign inst_o       = issue ? imem_inst_i : '0;
  assign inst_count_o = count;
  assign br_wait_o    = (state == BR_WAIT);
  assign misalign_o   = misalign;
  assign wdog_o       = wdog;

`ifdef FE_PERF_CNT_EN
  logic [31:0] perf_stall, perf_brwait, perf_redir;

  // Saturating event counters: stalled RUN cycles, BR_WAIT cycles, accepted redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall  <= '0;
      perf_brwait <= '0;
      perf_redir  <= '0;
    end else begin
      if ((state == RUN) && de_stall_i && (perf_stall != 32'hFFFF_FFFF)) begin
        perf_stall <= perf_stall + 32'd1;
      end
      if ((state == BR_WAIT) && (perf_brwait != 32'hFFFF_FFFF)) begin
        perf_brwait <= perf_brwait + 32'd1;
      end
      if ((state == BR_WAIT) && br_taken_i && (perf_redir != 32'hFFFF_FFFF)) begin
        perf_redir <= perf_redir + 32'd1;
      end
    end
  end

  assign perf_stall_o  = perf_stall;
  assign perf_brwait_o = perf_brwait;
  assign perf_redir_o  = perf_redir;
`endif

endmodule

// File: tb/tb_fe_pc_sequencer.sv
// tb_fe_pc_sequencer: directed scenarios for fe_pc_sequencer with hand-computed expectations.
// Instruction memory is a small array indexed by pc_o[9:2], filled per scenario.
module tb_fe_pc_sequencer;

  localparam int          WAIT_LIMIT = 16;
  localparam logic [31:0] ADDI = 32'h0000_0013;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] BNE  = 32'h0000_1063;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] JALR = 32'h0000_0067;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_inst;
  logic        de_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        br_resolved;
  logic [31:0] pc, pcplus, inst, inst_count;
  logic        fe_valid, br_wait, misalign, wdog;
`ifdef FE_PERF_CNT_EN
  logic [31:0] perf_stall, perf_brwait, perf_redir;
`endif

  logic [31:0] mem [0:255];
  int n_compared   = 0;
  int n_mismatched = 0;

  fe_pc_sequencer #(
    .DBITS(32), .INSTBITS(32), .RESET_PC(32'h0), .WAIT_LIMIT(WAIT_LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .imem_inst_i(imem_inst), .de_stall_i(de_stall),
    .br_taken_i(br_taken), .br_target_i(br_target), .br_resolved_i(br_resolved),
    .pc_o(pc), .pcplus_o(pcplus), .inst_o(inst), .inst_count_o(inst_count),
    .fe_valid_o(fe_valid), .br_wait_o(br_wait), .misalign_o(misalign), .wdog_o(wdog)
`ifdef FE_PERF_CNT_EN
    , .perf_stall_o(perf_stall), .perf_brwait_o(perf_brwait), .perf_redir_o(perf_redir)
`endif
  );

  always #5 clk = ~clk;

  assign imem_inst = mem[pc[9:2]];

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = ADDI;
  endtask

  // Advance one clock; inputs/outputs are then handled 2ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; de_stall = 1'b0; br_taken = 1'b0; br_resolved = 1'b0; br_target = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    fill_mem();
    do_reset();
    n_compared++; if (pc !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_pc: got %0h expected 0", pc); end
    n_compared++; if (inst_count !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_count: got %0h expected 0", inst_count); end
    n_compared++; if (br_wait !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_brwait: got %0b expected 0", br_wait); end
    n_compared++; if (misalign !== 1'b0 || wdog !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_flags: got %0b%0b expected 00", misalign, wdog); end
    n_compared++; if (pcplus !== 32'h4) begin n_mismatched++; $display("[TB] FAIL reset_pcplus: got %0h expected 4", pcplus); end
  endtask

  task automatic test_addi_stream();
    for (int i = 0; i < 4; i++) begin
      n_compared++; if (pc !== 32'(4 * i)) begin n_mismatched++; $display("[TB] FAIL stream_pc[%0d]: got %0h expected %0h", i, pc, 4 * i); end
      n_compared++; if (inst_count !== 32'(i)) begin n_mismatched++; $display("[TB] FAIL stream_count[%0d]: got %0h expected %0h", i, inst_count, i); end
      n_compared++; if (fe_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL stream_valid[%0d]: got %0b expected 1", i, fe_valid); end
      n_compared++; if (inst !== ADDI) begin n_mismatched++; $display("[TB] FAIL stream_inst[%0d]: got %0h expected %0h", i, inst, ADDI); end
      step();
    end
  endtask

  task automatic test_stall();
    fill_mem();
    do_reset();
    step(); step();
    de_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_compared++; if (pc !== 32'h8) begin n_mismatched++; $display("[TB] FAIL stall_pc[%0d]: got %0h expected 8", i, pc); end
      n_compared++; if (inst_count !== 32'h2) begin n_mismatched++; $display("[TB] FAIL stall_count[%0d]: got %0h expected 2", i, inst_count); end
      n_compared++; if (fe_valid !== 1'b0 || inst !== 32'h0) begin n_mismatched++; $display("[TB] FAIL stall_valid[%0d]: got %0b/%0h expected 0/0", i, fe_valid, inst); end
      step();
    end
    de_stall = 1'b0;
    #1;
    n_compared++; if (pc !== 32'h8 || fe_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL stall_resume: got pc %0h valid %0b expected 8/1", pc, fe_valid); end
    step();
    n_compared++; if (pc !== 32'hC || inst_count !== 32'h3) begin n_mismatched++; $display("[TB] FAIL stall_after: got pc %0h count %0h expected C/3", pc, inst_count); end
  endtask

  task automatic test_run_ignores_branch();
    fill_mem();
    do_reset();
    br_taken = 1'b1; br_resolved = 1'b1; br_target = 32'h80;
    step();
    br_taken = 1'b0; br_resolved = 1'b0;
    n_compared++; if (pc !== 32'h4 || br_wait !== 1'b0) begin n_mismatched++; $display("[TB] FAIL run_ignore: got pc %0h brwait %0b expected 4/0", pc, br_wait); end
  endtask

  task automatic test_branch_taken();
    fill_mem();
    mem[4] = BEQ;
    do_reset();
    repeat (4) step();
    n_compared++; if (pc !== 32'h10 || inst !== BEQ || fe_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL beq_issue: got pc %0h inst %0h valid %0b expected 10/%0h/1", pc, inst, fe_valid, BEQ); end
    step();
    n_compared++; if (br_wait !== 1'b1 || fe_valid !== 1'b0 || pc !== 32'h14) begin n_mismatched++; $display("[TB] FAIL beq_bubble1: got brwait %0b valid %0b pc %0h expected 1/0/14", br_wait, fe_valid, pc); end
    n_compared++; if (inst_count !== 32'h5) begin n_mismatched++; $display("[TB] FAIL beq_count: got %0h expected 5", inst_count); end
    step();
    br_taken = 1'b1; br_target = 32'h40;
    #1;
    n_compared++; if (br_wait !== 1'b1 || fe_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL beq_bubble2: got brwait %0b valid %0b expected 1/0", br_wait, fe_valid); end
    step();
    br_taken = 1'b0;
    n_compared++; if (pc !== 32'h40 || fe_valid !== 1'b1 || br_wait !== 1'b0) begin n_mismatched++; $display("[TB] FAIL beq_redirect: got pc %0h valid %0b brwait %0b expected 40/1/0", pc, fe_valid, br_wait); end
    n_compared++; if (inst_count !== 32'h5 || misalign !== 1'b0) begin n_mismatched++; $display("[TB] FAIL beq_after: got count %0h misalign %0b expected 5/0", inst_count, misalign); end
  endtask

  task automatic test_branch_not_taken();
    fill_mem();
    mem[8] = BNE;
    do_reset();
    repeat (8) step();
    n_compared++; if (pc !== 32'h20 || inst !== BNE) begin n_mismatched++; $display("[TB] FAIL bne_issue: got pc %0h inst %0h expected 20/%0h", pc, inst, BNE); end
    step();
    br_resolved = 1'b1;
    #1;
    n_compared++; if (pc !== 32'h24 || fe_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bne_bubble: got pc %0h valid %0b expected 24/0", pc, fe_valid); end
    step();
    br_resolved = 1'b0;
    n_compared++; if (pc !== 32'h24 || fe_valid !== 1'b1 || br_wait !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bne_resume: got pc %0h valid %0b brwait %0b expected 24/1/0", pc, fe_valid, br_wait); end
    n_compared++; if (inst_count !== 32'h9) begin n_mismatched++; $display("[TB] FAIL bne_count: got %0h expected 9", inst_count); end
  endtask

  task automatic test_jalr_both();
    fill_mem();
    mem[0] = JALR;
    do_reset();
    n_compared++; if (inst !== JALR || fe_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL jalr_issue: got inst %0h valid %0b expected %0h/1", inst, fe_valid, JALR); end
    step();
    br_taken = 1'b1; br_resolved = 1'b1; br_target = 32'h103;
    step();
    br_taken = 1'b0; br_resolved = 1'b0;
    n_compared++; if (pc !== 32'h100 || pcplus !== 32'h104) begin n_mismatched++; $display("[TB] FAIL jalr_target: got pc %0h pcplus %0h expected 100/104", pc, pcplus); end
    n_compared++; if (misalign !== 1'b1) begin n_mismatched++; $display("[TB] FAIL jalr_misalign: got %0b expected 1", misalign); end
    n_compared++; if (inst_count !== 32'h1 || fe_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL jalr_after: got count %0h valid %0b expected 1/1", inst_count, fe_valid); end
    step();
    n_compared++; if (misalign !== 1'b1 || pc !== 32'h104) begin n_mismatched++; $display("[TB] FAIL misalign_sticky: got misalign %0b pc %0h expected 1/104", misalign, pc); end
  endtask

  task automatic test_watchdog_and_reset();
    fill_mem();
    mem[0] = JAL;
    do_reset();
    n_compared++; if (misalign !== 1'b0) begin n_mismatched++; $display("[TB] FAIL misalign_cleared: got %0b expected 0", misalign); end
    step();
    repeat (WAIT_LIMIT - 2) step();
    n_compared++; if (wdog !== 1'b0 || br_wait !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wdog_early: got wdog %0b brwait %0b expected 0/1", wdog, br_wait); end
    repeat (2) step();
    n_compared++; if (wdog !== 1'b1 || br_wait !== 1'b1 || pc !== 32'h4) begin n_mismatched++; $display("[TB] FAIL wdog_set: got wdog %0b brwait %0b pc %0h expected 1/1/4", wdog, br_wait, pc); end
    reset = 1'b1; br_taken = 1'b1; br_target = 32'h80;
    @(posedge clk);
    #1;
    reset = 1'b0; br_taken = 1'b0;
    #1;
    n_compared++; if (pc !== 32'h0 || inst_count !== 32'h0) begin n_mismatched++; $display("[TB] FAIL wdog_reset_pc: got pc %0h count %0h expected 0/0", pc, inst_count); end
    n_compared++; if (br_wait !== 1'b0 || fe_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wdog_reset_state: got brwait %0b valid %0b expected 0/1", br_wait, fe_valid); end
    n_compared++; if (wdog !== 1'b0 || misalign !== 1'b0) begin n_mismatched++; $display("[TB] FAIL wdog_reset_flags: got wdog %0b misalign %0b expected 0/0", wdog, misalign); end
  endtask

  initial begin
    reset = 1'b1; de_stall = 1'b0; br_taken = 1'b0; br_resolved = 1'b0; br_target = '0;
    test_reset();
    test_addi_stream();
    test_stall();
    test_run_ignores_branch();
    test_branch_taken();
    test_branch_not_taken();
    test_jalr_both();
    test_watchdog_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
